// File: rtl/fsk_demod.sv
// fsk_demod: binary-FSK period classifier and per-symbol majority-vote bit recovery
// ports: clk system clock; reset async active-low; fsk_in async FSK square wave;
//        bit_out recovered bit (held between strobes); bit_valid one-cycle strobe;
//        sym_err window had a tie or an out-of-tolerance period; locked high in TRACK
module fsk_demod #(
  parameter int CNT_W       = 8,
  parameter int F1_PERIOD   = 4,
  parameter int F0_PERIOD   = 8,
  parameter int TOL         = 1,
  parameter int SYMBOL_CLKS = 64,
  parameter int TIMEOUT     = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic fsk_in,
  output logic bit_out,
  output logic bit_valid,
  output logic sym_err,
  output logic locked
);
  typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAXC = '1;
  localparam logic [CNT_W-1:0] F1   = CNT_W'(F1_PERIOD);
  localparam logic [CNT_W-1:0] F0   = CNT_W'(F0_PERIOD);
  localparam logic [CNT_W-1:0] TOLC = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] SYMC = CNT_W'(SYMBOL_CLKS);
  localparam logic [CNT_W-1:0] TOC  = CNT_W'(TIMEOUT);
  state_t state;
  logic [2:0] sync;
  logic [CNT_W-1:0] per_cnt, win_cnt, ones_cnt, zeros_cnt, ones_nx, zeros_nx, d1, d0;
  logic err_flag, err_nx, edge_det, is_mark, is_space, is_inv, timeout, win_end;
  assign edge_det = sync[1] & ~sync[2];
  assign d1       = per_cnt > F1 ? per_cnt - F1 : F1 - per_cnt;
  assign d0       = per_cnt > F0 ? per_cnt - F0 : F0 - per_cnt;
  assign is_mark  = d1 <= TOLC;
  assign is_space = !is_mark && d0 <= TOLC;
  assign is_inv   = !is_mark && !is_space;
  assign timeout  = per_cnt >= TOC;
  assign win_end  = win_cnt == SYMC;
  // next counts include a period ending this cycle, so a window-end decision sees it
  assign ones_nx  = (edge_det && is_mark && ones_cnt != MAXC) ? ones_cnt + ONE : ones_cnt;
  assign zeros_nx = (edge_det && is_space && zeros_cnt != MAXC) ? zeros_cnt + ONE : zeros_cnt;
  assign err_nx   = err_flag | (edge_det & is_inv);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sync      <= '0;
      per_cnt   <= '0;
      win_cnt   <= '0;
      ones_cnt  <= '0;
      zeros_cnt <= '0;
      err_flag  <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      sym_err   <= 1'b0;
      locked    <= 1'b0;
    end else begin
      sync      <= {sync[1:0], fsk_in};
      per_cnt   <= edge_det ? ONE : (per_cnt == MAXC ? per_cnt : per_cnt + ONE);
      bit_valid <= 1'b0;
      sym_err   <= 1'b0;
      case (state)
        IDLE: if (edge_det) state <= ACQ;
        ACQ: begin
          if (edge_det && !is_inv) begin
            state     <= TRACK;
            locked    <= 1'b1;
            win_cnt   <= ONE;
            ones_cnt  <= ones_nx;
            zeros_cnt <= zeros_nx;
          end else if (timeout) state <= IDLE;
        end
        TRACK: begin
          if (timeout) begin
            state     <= IDLE;
            locked    <= 1'b0;
            win_cnt   <= '0;
            ones_cnt  <= '0;
            zeros_cnt <= '0;
            err_flag  <= 1'b0;
          end else if (win_end) begin
            bit_valid <= 1'b1;
            bit_out   <= ones_nx > zeros_nx;
            sym_err   <= err_nx | (ones_nx == zeros_nx);
            win_cnt   <= ONE;
            ones_cnt  <= '0;
            zeros_cnt <= '0;
            err_flag  <= 1'b0;
          end else begin
            win_cnt   <= win_cnt + ONE;
            ones_cnt  <= ones_nx;
            zeros_cnt <= zeros_nx;
            err_flag  <= err_nx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fsk_demod.sv
// tb_fsk_demod: directed bench for fsk_demod; waveforms are indexed by the clock edge that samples them
module tb_fsk_demod;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic fsk_in = 1'b0;
  logic bit_out, bit_valid, sym_err, locked;
  int checks = 0;
  int errors = 0;
  logic fw [0:511];
  logic rv [0:511];
  logic rb [0:511];
  logic re [0:511];
  logic rl [0:511];
  always #5 clk = ~clk;
  fsk_demod dut (
    .clk(clk),
    .reset(reset),
    .fsk_in(fsk_in),
    .bit_out(bit_out),
    .bit_valid(bit_valid),
    .sym_err(sym_err),
    .locked(locked)
  );
  task clear_wave;
    for (int i = 0; i < 512; i++) fw[i] = 1'b0;
  endtask
  task tone(input int m0, input int p, input int cnt);
    for (int k = 0; k < cnt; k++)
      if (m0 + k * p + 1 < 512) begin
        fw[m0 + k * p] = 1'b1;
        fw[m0 + k * p + 1] = 1'b1;
      end
  endtask
  task do_reset;
    reset = 1'b0;
    fsk_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask
  task play(input int n_max);
    for (int n = 1; n <= n_max; n++) begin
      fsk_in = fw[n];
      @(posedge clk);
      #1;
      rv[n] = bit_valid;
      rb[n] = bit_out;
      re[n] = sym_err;
      rl[n] = locked;
    end
  endtask
  function automatic int strobes(input int a, input int b);
    int c = 0;
    for (int n = a; n <= b; n++) if (rv[n] === 1'b1) c++;
    return c;
  endfunction
  task check_strobe(input string name, input int q, input logic eb, input logic ee);
    checks++;
    if (rv[q] !== 1'b1 || rb[q] !== eb || re[q] !== ee) begin
      errors++;
      $display("FAIL %s@%0d: got valid=%b bit=%b err=%b expected valid=1 bit=%b err=%b",
               name, q, rv[q], rb[q], re[q], eb, ee);
    end
  endtask
  task test_reset;
    int bad;
    bad = 0;
    reset = 1'b0;
    for (int n = 0; n < 24; n++) begin
      fsk_in = n[1];
      @(posedge clk);
      #1;
      if ({bit_out, bit_valid, sym_err, locked} !== 4'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_outputs: got %0d nonzero cycles expected 0", bad);
    end
    do_reset;
    clear_wave;
    tone(4, 4, 20);
    play(20);
    checks++;
    if (rl[9] !== 1'b0) begin
      errors++;
      $display("FAIL acq_unlocked: got locked=%b expected 0", rl[9]);
    end
    checks++;
    if (rl[10] !== 1'b1) begin
      errors++;
      $display("FAIL second_edge_lock: got locked=%b expected 1", rl[10]);
    end
  endtask
  task test_mark_windows;
    int c;
    do_reset;
    clear_wave;
    tone(4, 4, 60);
    play(210);
    check_strobe("mark_w1", 74, 1'b1, 1'b0);
    check_strobe("mark_w2", 138, 1'b1, 1'b0);
    check_strobe("mark_w3", 202, 1'b1, 1'b0);
    c = strobes(1, 210);
    checks++;
    if (c != 3) begin
      errors++;
      $display("FAIL mark_strobe_count: got %0d expected 3", c);
    end
    checks++;
    if (rv[75] !== 1'b0 || re[75] !== 1'b0 || rb[75] !== 1'b1) begin
      errors++;
      $display("FAIL strobe_one_cycle: got valid=%b err=%b bit=%b expected valid=0 err=0 bit=1",
               rv[75], re[75], rb[75]);
    end
  endtask
  task test_back_to_back;
    int c;
    do_reset;
    clear_wave;
    tone(4, 8, 10);
    tone(80, 4, 20);
    play(150);
    check_strobe("space_window", 78, 1'b0, 1'b0);
    check_strobe("switch_to_mark", 142, 1'b1, 1'b0);
    c = strobes(1, 150);
    checks++;
    if (c != 2) begin
      errors++;
      $display("FAIL b2b_strobe_count: got %0d expected 2", c);
    end
  endtask
  task test_tie;
    int c;
    int rises [11] = '{4, 8, 16, 20, 28, 32, 40, 44, 52, 56, 64};
    do_reset;
    clear_wave;
    foreach (rises[i]) tone(rises[i], 4, 1);
    play(80);
    check_strobe("tie", 74, 1'b0, 1'b1);
    checks++;
    if (re[75] !== 1'b0) begin
      errors++;
      $display("FAIL tie_err_clear: got %b expected 0", re[75]);
    end
    c = strobes(1, 80);
    checks++;
    if (c != 1) begin
      errors++;
      $display("FAIL tie_strobe_count: got %0d expected 1", c);
    end
  endtask
  task test_invalid_period;
    do_reset;
    clear_wave;
    tone(4, 4, 5);
    tone(26, 4, 30);
    play(145);
    check_strobe("invalid_p6", 74, 1'b1, 1'b1);
    check_strobe("err_cleared_next", 138, 1'b1, 1'b0);
  endtask
  task test_carrier_loss;
    int c;
    do_reset;
    clear_wave;
    tone(4, 4, 8);
    tone(100, 4, 10);
    play(140);
    checks++;
    if (rl[65] !== 1'b1 || rl[66] !== 1'b0) begin
      errors++;
      $display("FAIL loss_timing: got locked@65=%b @66=%b expected 1 0", rl[65], rl[66]);
    end
    c = strobes(1, 140);
    checks++;
    if (c != 0) begin
      errors++;
      $display("FAIL loss_no_strobe: got %0d expected 0", c);
    end
    checks++;
    if (rl[105] !== 1'b0 || rl[106] !== 1'b1) begin
      errors++;
      $display("FAIL relock: got locked@105=%b @106=%b expected 0 1", rl[105], rl[106]);
    end
  endtask
  task test_reset_mid;
    do_reset;
    clear_wave;
    tone(4, 4, 20);
    play(40);
    checks++;
    if (rl[40] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_lock: got %b expected 1", rl[40]);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0 || bit_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got locked=%b valid=%b expected 0 0", locked, bit_valid);
    end
    do_reset;
    play(12);
    checks++;
    if (rl[9] !== 1'b0 || rl[10] !== 1'b1) begin
      errors++;
      $display("FAIL resume_after_reset: got locked@9=%b @10=%b expected 0 1", rl[9], rl[10]);
    end
  endtask
  initial begin
    test_reset;
    test_mark_windows;
    test_back_to_back;
    test_tie;
    test_invalid_period;
    test_carrier_loss;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
